// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, control-field encodings and the decoded control bundle
// used by the decode stage and its opcode lookup table.
package cpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLE   = 6'b000111;
   localparam logic [5:0] OP_BLT   = 6'b000110;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_FUNCT = 3'b010,
      ALU_LUI   = 3'b011,
      ALU_OR    = 3'b100
   } alu_op_e;

   typedef enum logic [1:0] {
      DST_RT  = 2'b00,
      DST_RD  = 2'b01,
      DST_R31 = 2'b10
   } reg_dst_e;

   typedef enum logic [1:0] {
      BR_EQ = 2'b00,
      BR_LE = 2'b01,
      BR_LT = 2'b10,
      BR_NE = 2'b11
   } branch_type_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b11
   } mem_to_reg_e;

   typedef struct packed {
      alu_op_e      alu_op;
      logic         alu_src;
      logic         reg_write;
      reg_dst_e     reg_dst;
      logic         branch;
      branch_type_e branch_type;
      mem_to_reg_e  mem_to_reg;
      logic         mem_read;
      logic         mem_write;
      logic         jump;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_lut.sv
// Combinational opcode-to-control table; unknown opcodes yield an all-zero bundle
// and raise illegal.
module ctrl_lut
   import cpu_ctrl_pkg::*;
#(
   parameter int OP_W       = 6,
   parameter bit EXT_BRANCH = 1'b1
) (
   input  logic [OP_W-1:0] op,
   output ctrl_t           ctrl,
   output logic            illegal
);

   always_comb begin
      ctrl    = CTRL_NOP;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctrl.alu_op    = ALU_FUNCT;
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = DST_RD;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_MEM;
            ctrl.mem_read   = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.branch = 1'b1;
         end
         OP_BNE: begin
            ctrl.alu_op      = ALU_SUB;
            ctrl.branch      = 1'b1;
            ctrl.branch_type = BR_NE;
         end
         OP_BLE: begin
            if (EXT_BRANCH) begin
               ctrl.alu_op      = ALU_SUB;
               ctrl.branch      = 1'b1;
               ctrl.branch_type = BR_LE;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_BLT: begin
            if (EXT_BRANCH) begin
               ctrl.alu_op      = ALU_SUB;
               ctrl.branch      = 1'b1;
               ctrl.branch_type = BR_LT;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_LUI: begin
            ctrl.alu_op    = ALU_LUI;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_ORI: begin
            ctrl.alu_op    = ALU_OR;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DST_R31;
            ctrl.mem_to_reg = WB_PC4;
            ctrl.jump       = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_decoder.sv
// Single registered decode stage with valid/ready handshake, load-use bubble
// insertion, flush and a saturating stall counter.
module pipe_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int OP_W       = 6,
   parameter int REG_W      = 5,
   parameter int CNT_W      = 16,
   parameter bit EXT_BRANCH = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic [31:0]      instr_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             reg_write_o,
   output logic [2:0]       alu_op_o,
   output logic             alu_src_o,
   output logic [1:0]       reg_dst_o,
   output logic             branch_o,
   output logic [1:0]       branch_type_o,
   output logic             jump_o,
   output logic [1:0]       mem_to_reg_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             illegal_o,
   output logic [REG_W-1:0] dst_reg_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Handshake: a word moves in when in_valid_i && in_ready_o at a clk_i edge;
   // the held bundle leaves when out_valid_o && out_ready_i. in_ready_o is built
   // only from registered state, instr_i, out_ready_i and flush_i.

   logic [OP_W-1:0]  op;
   logic [REG_W-1:0] rs, rt, rd;
   logic             unused_imm;

   assign op         = instr_i[31 -: OP_W];
   assign rs         = instr_i[25 -: REG_W];
   assign rt         = instr_i[20 -: REG_W];
   assign rd         = instr_i[15 -: REG_W];
   assign unused_imm = ^instr_i[10:0];

   ctrl_t dec;
   logic  dec_illegal;

   ctrl_lut #(
      .OP_W       (OP_W),
      .EXT_BRANCH (EXT_BRANCH)
   ) u_lut (
      .op      (op),
      .ctrl    (dec),
      .illegal (dec_illegal)
   );

   logic [REG_W-1:0] dst_nxt;

   always_comb begin
      dst_nxt = rt;
      case (dec.reg_dst)
         DST_RD:  dst_nxt = rd;
         DST_R31: dst_nxt = REG_W'(31);
         default: dst_nxt = rt;
      endcase
   end

   ctrl_t            held;
   logic             out_valid_q;
   logic             illegal_q;
   logic [REG_W-1:0] dst_q;
   logic [CNT_W-1:0] stall_cnt_q;

   // Load-use: the held load's target is read by the incoming word. rt is only a
   // source for R-type, stores and branches; elsewhere it is a destination.
   logic uses_rt, hazard, advance, accept;

   assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || dec.branch;
   assign hazard  = out_valid_q && held.mem_read && (dst_q != '0) &&
                    ((dst_q == rs) || (uses_rt && (dst_q == rt)));
   assign advance    = !out_valid_q || out_ready_i;
   assign in_ready_o = advance && !hazard && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         held        <= CTRL_NOP;
         illegal_q   <= 1'b0;
         dst_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         // Empty slots (bubble, flush, idle) load zeros so controls read 0.
         if (flush_i || advance) begin
            out_valid_q <= accept;
            held        <= accept ? dec : CTRL_NOP;
            illegal_q   <= accept && dec_illegal;
            dst_q       <= accept ? dst_nxt : '0;
         end
         if (!flush_i && out_ready_i && hazard && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign out_valid_o   = out_valid_q;
   assign reg_write_o   = held.reg_write;
   assign alu_op_o      = held.alu_op;
   assign alu_src_o     = held.alu_src;
   assign reg_dst_o     = held.reg_dst;
   assign branch_o      = held.branch;
   assign branch_type_o = held.branch_type;
   assign jump_o        = held.jump;
   assign mem_to_reg_o  = held.mem_to_reg;
   assign mem_read_o    = held.mem_read;
   assign mem_write_o   = held.mem_write;
   assign illegal_o     = illegal_q;
   assign dst_reg_o     = dst_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule
